mpc_sample_sched: RTL and testbench

Control-period scheduler sitting directly upstream of the MPC solver core and its output-hold stage. Generates the fixed sampling tick, snapshots the measurement and reference words so the solver sees a frame that cannot change mid-solve, issues a one-cycle start pulse, and waits for the solver's result-valid strobe (the same strobe that drives the downstream hold register). Overrun and timeout conditions are detected and reported through sticky flags.

---
 rtl/mpc_sample_sched.sv | 101 ++++++++++
 tb/tb_mpc_sample_sched.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mpc_sample_sched.sv
// rtl/mpc_sample_sched.sv - control-period scheduler: sample tick, frame latch, solver start and watchdog
module mpc_sample_sched #(
  parameter int PERIOD  = 10000,
  parameter int TIMEOUT = 9000
) (
  input  logic        clk_1,
  input  logic        rst_n,
  input  logic        ce_1,
  input  logic [31:0] meas0_in,
  input  logic [31:0] meas1_in,
  input  logic [31:0] ref_in,
  input  logic        solver_valid,
  input  logic        clr_flags,
  output logic [31:0] meas0_out,
  output logic [31:0] meas1_out,
  output logic [31:0] ref_out,
  output logic        start,
  output logic        busy,
  output logic        overrun,
  output logic        timeout,
  output logic [7:0]  ovr_cnt,
  output logic [15:0] sample_cnt
);

  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int BW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_WAIT,
    S_START,
    S_BUSY
  } state_t;

  state_t        state;
  logic [PW-1:0] pcnt;
  logic [BW-1:0] bcnt;
  logic          tick;
  logic [7:0]    ovr_base;

  assign tick     = ce_1 && (pcnt == PW'(PERIOD - 1));
  assign start    = ce_1 && (state == S_START);
  assign busy     = (state != S_WAIT);
  // Clear is applied first so that a simultaneous overrun still counts from zero.
  assign ovr_base = clr_flags ? 8'd0 : ovr_cnt;

  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_WAIT;
      pcnt       <= '0;
      bcnt       <= '0;
      meas0_out  <= '0;
      meas1_out  <= '0;
      ref_out    <= '0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
      ovr_cnt    <= '0;
      sample_cnt <= '0;
    end else if (ce_1) begin
      pcnt <= tick ? '0 : pcnt + 1'b1;

      if (clr_flags) begin
        overrun <= 1'b0;
        timeout <= 1'b0;
        ovr_cnt <= 8'd0;
      end
      if (tick && state != S_WAIT) begin
        overrun <= 1'b1;
        ovr_cnt <= (ovr_base == 8'hFF) ? 8'hFF : ovr_base + 8'd1;
      end

      case (state)
        S_WAIT: begin
          if (tick) begin
            meas0_out <= meas0_in;
            meas1_out <= meas1_in;
            ref_out   <= ref_in;
            state     <= S_START;
          end
        end
        S_START: begin
          bcnt  <= '0;
          state <= S_BUSY;
        end
        S_BUSY: begin
          // bcnt lags the enabled cycles since start by one, so TIMEOUT-2 lands the abort on start+TIMEOUT.
          if (solver_valid) begin
            sample_cnt <= sample_cnt + 16'd1;
            state      <= S_WAIT;
          end else if (bcnt == BW'(TIMEOUT - 2)) begin
            timeout <= 1'b1;
            state   <= S_WAIT;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_mpc_sample_sched.sv
// tb/tb_mpc_sample_sched.sv - randomized bench for mpc_sample_sched against a frame-level reference model
module tb_mpc_sample_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic [31:0] m0_in = '0, m1_in = '0, r_in = '0;
  logic        valid = 1'b0;
  logic        clr = 1'b0;

  logic [31:0] a_m0, a_m1, a_r, b_m0, b_m1, b_r;
  logic        a_start, a_busy, a_ovr, a_to, b_start, b_busy, b_ovr, b_to;
  logic [7:0]  a_oc, b_oc;
  logic [15:0] a_sc, b_sc;

  int vectors = 0;
  int errors  = 0;

  // Model state per instance: 0 = PERIOD 8 / TIMEOUT 6, 1 = PERIOD 8 / TIMEOUT 12
  int          pp[2] = '{8, 8};
  int          tt[2] = '{6, 12};
  int          pc[2], el[2], oc[2], sc[2];
  bit          inflight[2], ovr[2], to[2];
  logic [31:0] lm0[2], lm1[2], lr[2];

  mpc_sample_sched #(.PERIOD(8), .TIMEOUT(6)) dut_a (
    .clk_1(clk), .rst_n(rst_n), .ce_1(ce),
    .meas0_in(m0_in), .meas1_in(m1_in), .ref_in(r_in),
    .solver_valid(valid), .clr_flags(clr),
    .meas0_out(a_m0), .meas1_out(a_m1), .ref_out(a_r),
    .start(a_start), .busy(a_busy), .overrun(a_ovr), .timeout(a_to),
    .ovr_cnt(a_oc), .sample_cnt(a_sc)
  );

  mpc_sample_sched #(.PERIOD(8), .TIMEOUT(12)) dut_b (
    .clk_1(clk), .rst_n(rst_n), .ce_1(ce),
    .meas0_in(m0_in), .meas1_in(m1_in), .ref_in(r_in),
    .solver_valid(valid), .clr_flags(clr),
    .meas0_out(b_m0), .meas1_out(b_m1), .ref_out(b_r),
    .start(b_start), .busy(b_busy), .overrun(b_ovr), .timeout(b_to),
    .ovr_cnt(b_oc), .sample_cnt(b_sc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mreset(input int d);
    pc[d] = 0; el[d] = 0; oc[d] = 0; sc[d] = 0;
    inflight[d] = 0; ovr[d] = 0; to[d] = 0;
    lm0[d] = '0; lm1[d] = '0; lr[d] = '0;
  endtask

  task automatic mupdate(input int d);
    bit tick;
    if (!rst_n) begin
      mreset(d);
    end else if (ce) begin
      tick  = (pc[d] == pp[d] - 1);
      pc[d] = (pc[d] + 1) % pp[d];
      if (clr) begin ovr[d] = 0; to[d] = 0; oc[d] = 0; end
      if (inflight[d]) begin
        if (tick) begin ovr[d] = 1; oc[d] = (oc[d] < 255) ? oc[d] + 1 : 255; end
        if (el[d] > 0 && valid) begin
          sc[d] = (sc[d] + 1) % 65536;
          inflight[d] = 0;
        end else if (el[d] == tt[d] - 1) begin
          to[d] = 1;
          inflight[d] = 0;
        end else begin
          el[d]++;
        end
      end else if (tick) begin
        lm0[d] = m0_in; lm1[d] = m1_in; lr[d] = r_in;
        inflight[d] = 1; el[d] = 0;
      end
    end
  endtask

  task automatic check_dut(input int d, input logic [31:0] m0, input logic [31:0] m1,
                           input logic [31:0] r, input logic st, input logic bz,
                           input logic ov, input logic tm, input logic [7:0] oct,
                           input logic [15:0] sct);
    string n;
    n = (d == 0) ? "A" : "B";
    chk({n, ".meas0_out"}, m0, lm0[d]);
    chk({n, ".meas1_out"}, m1, lm1[d]);
    chk({n, ".ref_out"}, r, lr[d]);
    chk({n, ".start"}, 32'(st), 32'(ce && rst_n && inflight[d] && el[d] == 0));
    chk({n, ".busy"}, 32'(bz), 32'(inflight[d]));
    chk({n, ".overrun"}, 32'(ov), 32'(ovr[d]));
    chk({n, ".timeout"}, 32'(tm), 32'(to[d]));
    chk({n, ".ovr_cnt"}, 32'(oct), 32'(oc[d]));
    chk({n, ".sample_cnt"}, 32'(sct), 32'(sc[d]));
  endtask

  task automatic check_all();
    check_dut(0, a_m0, a_m1, a_r, a_start, a_busy, a_ovr, a_to, a_oc, a_sc);
    check_dut(1, b_m0, b_m1, b_r, b_start, b_busy, b_ovr, b_to, b_oc, b_sc);
  endtask

  // Inputs are set by the caller just after a rising edge; outputs checked mid-cycle.
  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    mupdate(0);
    mupdate(1);
    #1;
  endtask

  initial begin
    mreset(0);
    mreset(1);
    #2;
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ce    = 1'b1;
    m0_in = 32'h11;

    // Solver answers three enabled cycles after each start.
    for (int i = 0; i < 40; i++) begin
      if (i == 20) m0_in = 32'h22;
      valid = inflight[0] && el[0] == 3;
      step();
    end

    // Solver silent: A times out, B overruns.
    valid = 1'b0;
    for (int i = 0; i < 40; i++) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();

    // Clock enable every other cycle.
    for (int i = 0; i < 60; i++) begin
      ce    = i[0];
      valid = inflight[0] && el[0] == 3;
      step();
    end

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      ce    = ($urandom_range(0, 3) != 0);
      valid = ($urandom_range(0, 5) == 0);
      clr   = ($urandom_range(0, 30) == 0);
      m0_in = $urandom;
      m1_in = $urandom;
      r_in  = $urandom;
      step();
    end

    // Reset while a solve is in flight.
    ce = 1'b1; valid = 1'b0; clr = 1'b0;
    for (int i = 0; i < 40 && !(inflight[0] && el[0] > 0); i++) step();
    #1;
    chk("A.busy_before_reset", 32'(a_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    mreset(0);
    mreset(1);
    check_all();
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      valid = inflight[0] && el[0] == 2;
      m0_in = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
